// File: rtl/byte_bus_controller_if.sv
// Cache-side request port: the arbiter (master) presents one request and holds it until ready;
// the byte bus controller (slave) returns a one-cycle ready pulse with the little-endian result.
interface byte_bus_controller_if;
    logic        waiting;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] value;
    logic        ready;
    logic [31:0] result;

    modport master (
        output waiting, wr, len, addr, value,
        input  ready, result
    );

    modport slave (
        input  waiting, wr, len, addr, value,
        output ready, result
    );
endinterface

// File: rtl/byte_bus_controller.sv
// Splits one 1/2/4-byte cache request into single-byte RAM transactions; read ready N+1 cycles, write N cycles after acceptance.
// rdy_in low freezes every register and gates mem_wr; the requester must hold its request until the ready pulse.
module byte_bus_controller (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        RoB_clear,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [31:0]                 mem_a,
    output logic                        mem_wr,
    byte_bus_controller_if.slave        req
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state_q, state_nxt;
    logic [2:0]  cnt_q, cnt_nxt;
    logic [2:0]  n_q, n_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] value_q, value_nxt;
    logic [31:0] mem_a_q, mem_a_nxt;
    logic [7:0]  dout_q, dout_nxt;
    logic        mem_wr_q, mem_wr_nxt;
    logic [31:0] result_q, result_nxt;
    logic        ready_q, ready_nxt;
    logic        squash_q, squash_nxt;

    logic [2:0]  req_n;
    logic [31:0] next_a;
    logic [4:0]  rd_sel;
    logic [4:0]  wr_sel;
    logic        squash_now;

    assign req_n  = (req.len == 3'd0) ? 3'd1 : (req.len == 3'd1) ? 3'd2 : 3'd4;
    assign next_a = addr_q + {29'd0, cnt_q} + 32'd1;
    // Byte captured this edge belongs to the address presented one cycle earlier.
    assign rd_sel = {cnt_q[1:0] - 2'd1, 3'b000};
    assign wr_sel = {cnt_q[1:0] + 2'd1, 3'b000};
    assign squash_now = squash_q | RoB_clear;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            n_q      <= 3'd0;
            addr_q   <= 32'd0;
            value_q  <= 32'd0;
            mem_a_q  <= 32'd0;
            dout_q   <= 8'd0;
            mem_wr_q <= 1'b0;
            result_q <= 32'd0;
            ready_q  <= 1'b0;
            squash_q <= 1'b0;
        end else if (rdy_in) begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            n_q      <= n_nxt;
            addr_q   <= addr_nxt;
            value_q  <= value_nxt;
            mem_a_q  <= mem_a_nxt;
            dout_q   <= dout_nxt;
            mem_wr_q <= mem_wr_nxt;
            result_q <= result_nxt;
            ready_q  <= ready_nxt;
            squash_q <= squash_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        n_nxt      = n_q;
        addr_nxt   = addr_q;
        value_nxt  = value_q;
        mem_a_nxt  = mem_a_q;
        dout_nxt   = dout_q;
        mem_wr_nxt = mem_wr_q;
        result_nxt = result_q;
        ready_nxt  = 1'b0;
        squash_nxt = squash_q;

        case (state_q)
            IDLE: begin
                mem_a_nxt  = 32'd0;
                mem_wr_nxt = 1'b0;
                if (RoB_clear) begin
                    state_nxt = GAP;
                end else if (req.waiting) begin
                    addr_nxt   = req.addr;
                    value_nxt  = req.value;
                    n_nxt      = req_n;
                    cnt_nxt    = 3'd0;
                    mem_a_nxt  = req.addr;
                    result_nxt = 32'd0;
                    squash_nxt = 1'b0;
                    if (req.wr) begin
                        state_nxt  = WRITE;
                        dout_nxt   = req.value[7:0];
                        mem_wr_nxt = 1'b1;
                    end else begin
                        state_nxt  = READ;
                    end
                end
            end

            READ: begin
                if (RoB_clear) begin
                    state_nxt  = GAP;
                    result_nxt = 32'd0;
                    mem_a_nxt  = 32'd0;
                    cnt_nxt    = 3'd0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        result_nxt[rd_sel +: 8] = mem_din;
                    end
                    if (cnt_q == n_q) begin
                        state_nxt = DONE;
                        ready_nxt = 1'b1;
                    end else begin
                        if (cnt_q + 3'd1 < n_q) begin
                            mem_a_nxt = next_a;
                        end
                        cnt_nxt = cnt_q + 3'd1;
                    end
                end
            end

            WRITE: begin
                // A flush cannot cancel bytes already committed; it only suppresses the ready pulse.
                if (cnt_q + 3'd1 < n_q) begin
                    mem_a_nxt  = next_a;
                    dout_nxt   = value_q[wr_sel +: 8];
                    cnt_nxt    = cnt_q + 3'd1;
                    squash_nxt = squash_now;
                end else begin
                    state_nxt  = DONE;
                    ready_nxt  = ~squash_now;
                    mem_wr_nxt = 1'b0;
                    mem_a_nxt  = 32'd0;
                    cnt_nxt    = 3'd0;
                    squash_nxt = 1'b0;
                end
            end

            DONE: begin
                state_nxt = GAP;
            end

            GAP: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = dout_q;
    assign mem_wr     = mem_wr_q & rdy_in;
    assign req.ready  = ready_q;
    assign req.result = result_q;

endmodule

// File: tb/tb_byte_bus_controller.sv
// Bench for byte_bus_controller: synchronous byte RAM model plus a shadow memory used as the reference.
module tb_byte_bus_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        RoB_clear;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic        ld_vld;
    logic [15:0] ld_a;
    logic [7:0]  ld_d;

    bit [7:0]    dram [0:65535];
    int unsigned wcnt [0:65535];
    bit [7:0]    mdl  [0:65535];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    byte_bus_controller_if bus ();

    byte_bus_controller dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .RoB_clear (RoB_clear),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .req       (bus)
    );

    always @(posedge clk_in) begin
        if (ld_vld) begin
            dram[ld_a] <= ld_d;
        end else if (mem_wr) begin
            dram[mem_a[15:0]] <= mem_dout;
            wcnt[mem_a[15:0]] <= wcnt[mem_a[15:0]] + 1;
        end
        mem_din <= dram[mem_a[15:0]];
    end

    function automatic int nbytes(input logic [2:0] l);
        return (l == 3'd0) ? 1 : (l == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            r[8*i +: 8] = mdl[a[15:0]];
        end
        return r;
    endfunction

    task automatic load(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        ld_vld = 1'b1;
        ld_a   = a[15:0];
        ld_d   = d;
        mdl[a[15:0]] = d;
        @(negedge clk_in);
        ld_vld = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] l, input logic [31:0] a, input logic [31:0] v);
        bus.wr      = w;
        bus.len     = l;
        bus.addr    = a;
        bus.value   = v;
        bus.waiting = 1'b1;
    endtask

    // Latency is counted in clock edges from the sampling edge to the edge that raises ready.
    task automatic run_req(input logic w, input logic [2:0] l, input logic [31:0] a, input logic [31:0] v,
                           output int lat, output logic [31:0] res);
        lat = -1;
        res = 32'd0;
        @(negedge clk_in);
        issue(w, l, a, v);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            if (bus.ready === 1'b1) begin
                lat = c - 1;
                res = bus.result;
            end
        end
        bus.waiting = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        n_chk++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        n_chk++; if (mem_a !== 32'd0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
        n_chk++; if (mem_dout !== 8'd0) begin n_fail++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
        n_chk++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_word_read;
        int lat;
        logic [31:0] res;
        logic [31:0] exp_a;
        load(32'h100, 8'h11); load(32'h101, 8'h22); load(32'h102, 8'h33); load(32'h103, 8'h44);
        lat = -1; res = 32'd0;
        @(negedge clk_in);
        issue(1'b0, 3'd2, 32'h100, 32'd0);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            if (c <= 4) begin
                exp_a = 32'h100 + c - 1;
                n_chk++;
                if (mem_a !== exp_a) begin n_fail++; $display("FAIL word_read_addr[%0d]: got %h expected %h", c, mem_a, exp_a); end
            end
            if (bus.ready === 1'b1) begin lat = c - 1; res = bus.result; bus.waiting = 1'b0; end
        end
        bus.waiting = 1'b0;
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL word_read_latency: got %0d expected 5", lat); end
        n_chk++; if (res !== 32'h44332211) begin n_fail++; $display("FAIL word_read_result: got %h expected 44332211", res); end
        @(negedge clk_in);
        n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL word_read_pulse: got %b expected 0", bus.ready); end
        @(negedge clk_in);
    endtask

    task automatic test_half_write;
        int lat;
        int wr_cycles;
        int unsigned w0 [3];
        logic [31:0] a;
        load(32'h2001, 8'h00); load(32'h2002, 8'h00); load(32'h2003, 8'h5A);
        for (int i = 0; i < 3; i++) w0[i] = wcnt[16'h2001 + i];
        lat = -1; wr_cycles = 0;
        @(negedge clk_in);
        issue(1'b1, 3'd1, 32'h2001, 32'hDEADBEEF);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            if (mem_wr === 1'b1) wr_cycles++;
            if (bus.ready === 1'b1) begin lat = c - 1; bus.waiting = 1'b0; end
        end
        bus.waiting = 1'b0;
        mdl[16'h2001] = 8'hEF;
        mdl[16'h2002] = 8'hBE;
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL half_write_latency: got %0d expected 2", lat); end
        n_chk++; if (wr_cycles !== 2) begin n_fail++; $display("FAIL half_write_wr_cycles: got %0d expected 2", wr_cycles); end
        for (int i = 0; i < 3; i++) begin
            a = 32'h2001 + i;
            n_chk++;
            if (dram[a[15:0]] !== mdl[a[15:0]] || wcnt[a[15:0]] !== w0[i] + ((i < 2) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL half_write_byte[%h]: got %h (writes %0d) expected %h", a, dram[a[15:0]], wcnt[a[15:0]] - w0[i], mdl[a[15:0]]);
            end
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [31:0] res;
        load(32'h600, 8'hA5); load(32'h700, 8'h3C);
        lat = -1; res = 32'd0;
        @(negedge clk_in);
        issue(1'b0, 3'd0, 32'h600, 32'd0);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            if (bus.ready === 1'b1) begin lat = c - 1; res = bus.result; end
        end
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 2", lat); end
        n_chk++; if (res !== 32'h000000A5) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 000000a5", res); end
        bus.addr = 32'h700;
        @(negedge clk_in);
        n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_width: got %b expected 0", bus.ready); end
        n_chk++; if (mem_a === 32'h700) begin n_fail++; $display("FAIL b2b_early_gap: got %h expected not 00000700", mem_a); end
        @(negedge clk_in);
        n_chk++; if (mem_a === 32'h700) begin n_fail++; $display("FAIL b2b_early_idle: got %h expected not 00000700", mem_a); end
        @(negedge clk_in);
        n_chk++; if (mem_a !== 32'h700) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 00000700", mem_a); end
        lat = -1; res = 32'd0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            if (bus.ready === 1'b1) begin lat = c; res = bus.result; end
        end
        bus.waiting = 1'b0;
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 2", lat); end
        n_chk++; if (res !== 32'h0000003C) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 0000003c", res); end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_flush_read;
        int lat;
        int rdy_seen;
        logic [31:0] res;
        load(32'h500, 8'h9C); load(32'h501, 8'h12); load(32'h502, 8'h7E); load(32'h503, 8'h01);
        rdy_seen = 0;
        @(negedge clk_in);
        issue(1'b0, 3'd2, 32'h500, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            if (bus.ready === 1'b1) rdy_seen++;
        end
        RoB_clear   = 1'b1;
        bus.waiting = 1'b0;
        @(negedge clk_in);
        RoB_clear = 1'b0;
        n_chk++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL flush_read_result: got %h expected 0", bus.result); end
        for (int c = 0; c < 8; c++) begin
            if (bus.ready === 1'b1) rdy_seen++;
            @(negedge clk_in);
        end
        n_chk++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL flush_read_ready: got %0d pulses expected 0", rdy_seen); end
        run_req(1'b0, 3'd0, 32'h502, 32'd0, lat, res);
        n_chk++; if (lat !== 2 || res !== 32'h0000007E) begin n_fail++; $display("FAIL flush_read_recover: got lat %0d data %h expected lat 2 data 0000007e", lat, res); end
    endtask

    task automatic test_flush_write;
        int lat;
        int rdy_seen;
        logic [31:0] v;
        logic [31:0] res;
        logic [31:0] a;
        int unsigned w0 [4];
        v = $urandom;
        for (int i = 0; i < 4; i++) w0[i] = wcnt[16'h3000 + i];
        rdy_seen = 0;
        @(negedge clk_in);
        issue(1'b1, 3'd2, 32'h3000, v);
        @(negedge clk_in);
        if (bus.ready === 1'b1) rdy_seen++;
        @(negedge clk_in);
        RoB_clear   = 1'b1;
        bus.waiting = 1'b0;
        @(negedge clk_in);
        RoB_clear = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.ready === 1'b1) rdy_seen++;
            @(negedge clk_in);
        end
        for (int i = 0; i < 4; i++) mdl[16'h3000 + i] = v[8*i +: 8];
        n_chk++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL flush_write_ready: got %0d pulses expected 0", rdy_seen); end
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + i;
            n_chk++;
            if (dram[a[15:0]] !== mdl[a[15:0]] || wcnt[a[15:0]] !== w0[i] + 1) begin
                n_fail++;
                $display("FAIL flush_write_byte[%h]: got %h (writes %0d) expected %h once", a, dram[a[15:0]], wcnt[a[15:0]] - w0[i], mdl[a[15:0]]);
            end
        end
        run_req(1'b0, 3'd2, 32'h3000, 32'd0, lat, res);
        n_chk++; if (lat !== 5 || res !== v) begin n_fail++; $display("FAIL flush_write_readback: got lat %0d data %h expected lat 5 data %h", lat, res, v); end
    endtask

    task automatic test_stall_write;
        int lat;
        logic [31:0] v;
        logic [31:0] a2;
        logic [31:0] a;
        logic [7:0]  d2;
        int unsigned w0 [4];
        v = $urandom;
        for (int i = 0; i < 4; i++) w0[i] = wcnt[16'h3100 + i];
        lat = -1;
        @(negedge clk_in);
        issue(1'b1, 3'd2, 32'h3100, v);
        @(negedge clk_in);
        @(negedge clk_in);
        a2 = mem_a;
        d2 = mem_dout;
        n_chk++; if (a2 !== 32'h3101 || d2 !== v[15:8]) begin n_fail++; $display("FAIL stall_pre_state: got %h/%h expected 00003101/%h", a2, d2, v[15:8]); end
        rdy_in = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk_in);
            n_chk++;
            if (mem_wr !== 1'b0 || mem_a !== a2 || mem_dout !== d2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got wr %b a %h d %h expected wr 0 a %h d %h", c, mem_wr, mem_a, mem_dout, a2, d2);
            end
        end
        rdy_in = 1'b1;
        for (int c = 6; c <= 30 && lat < 0; c++) begin
            @(negedge clk_in);
            if (bus.ready === 1'b1) lat = c - 1;
        end
        bus.waiting = 1'b0;
        for (int i = 0; i < 4; i++) mdl[16'h3100 + i] = v[8*i +: 8];
        n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL stall_latency: got %0d expected 7", lat); end
        for (int i = 0; i < 4; i++) begin
            a = 32'h3100 + i;
            n_chk++;
            if (dram[a[15:0]] !== mdl[a[15:0]] || wcnt[a[15:0]] !== w0[i] + 1) begin
                n_fail++;
                $display("FAIL stall_byte[%h]: got %h (writes %0d) expected %h once", a, dram[a[15:0]], wcnt[a[15:0]] - w0[i], mdl[a[15:0]]);
            end
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset_mid_write;
        int lat;
        logic [31:0] res;
        @(negedge clk_in);
        issue(1'b1, 3'd2, 32'h3200, 32'h01020304);
        repeat (3) @(negedge clk_in);
        rst_in      = 1'b1;
        bus.waiting = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        n_chk++;
        if (mem_wr !== 1'b0 || bus.ready !== 1'b0 || mem_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_write: got wr %b ready %b a %h expected 0 0 0", mem_wr, bus.ready, mem_a);
        end
        run_req(1'b0, 3'd0, 32'h600, 32'd0, lat, res);
        n_chk++; if (lat !== 2 || res !== 32'h000000A5) begin n_fail++; $display("FAIL reset_recover: got lat %0d data %h expected lat 2 data 000000a5", lat, res); end
    endtask

    task automatic test_wrap;
        int lat;
        logic [31:0] res;
        load(32'hFFFE, 8'h10); load(32'hFFFF, 8'h20); load(32'h0000, 8'h30); load(32'h0001, 8'h40);
        lat = -1; res = 32'd0;
        @(negedge clk_in);
        issue(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk_in);
            if (c == 3) begin
                n_chk++;
                if (mem_a !== 32'd0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", mem_a); end
            end
            if (bus.ready === 1'b1) begin lat = c - 1; res = bus.result; end
        end
        bus.waiting = 1'b0;
        n_chk++; if (lat !== 5 || res !== 32'h40302010) begin n_fail++; $display("FAIL wrap_result: got lat %0d data %h expected lat 5 data 40302010", lat, res); end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_random;
        int lat;
        int n;
        logic        w;
        logic [2:0]  l;
        logic [31:0] a;
        logic [31:0] ab;
        logic [31:0] v;
        logic [31:0] res;
        logic [31:0] exp;
        int unsigned w0 [4];
        for (int i = 0; i < 260; i++) load(32'h8000 + i, 8'($urandom));
        for (int t = 0; t < 24; t++) begin
            w = 1'($urandom_range(0, 1));
            l = 3'($urandom_range(0, 7));
            a = 32'h8000 + $urandom_range(0, 255);
            v = $urandom;
            n = nbytes(l);
            if (w) begin
                for (int i = 0; i < 4; i++) begin ab = a + i; w0[i] = wcnt[ab[15:0]]; end
                run_req(w, l, a, v, lat, res);
                for (int i = 0; i < n; i++) begin ab = a + i; mdl[ab[15:0]] = v[8*i +: 8]; end
                n_chk++; if (lat !== n) begin n_fail++; $display("FAIL rand_write_latency[%0d]: got %0d expected %0d", t, lat, n); end
                for (int i = 0; i < 4; i++) begin
                    ab = a + i;
                    n_chk++;
                    if (dram[ab[15:0]] !== mdl[ab[15:0]] || wcnt[ab[15:0]] !== w0[i] + ((i < n) ? 1 : 0)) begin
                        n_fail++;
                        $display("FAIL rand_write_byte[%0d] @%h: got %h (writes %0d) expected %h", t, ab, dram[ab[15:0]], wcnt[ab[15:0]] - w0[i], mdl[ab[15:0]]);
                    end
                end
            end else begin
                exp = mdl_word(a, n);
                run_req(w, l, a, v, lat, res);
                n_chk++;
                if (lat !== n + 1 || res !== exp) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d] @%h len %0d: got lat %0d data %h expected lat %0d data %h", t, a, l, lat, res, n + 1, exp);
                end
            end
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        RoB_clear   = 1'b0;
        ld_vld      = 1'b0;
        ld_a        = 16'd0;
        ld_d        = 8'd0;
        bus.waiting = 1'b0;
        bus.wr      = 1'b0;
        bus.len     = 3'd0;
        bus.addr    = 32'd0;
        bus.value   = 32'd0;

        test_reset;
        test_word_read;
        test_half_write;
        test_back_to_back;
        test_flush_read;
        test_flush_write;
        test_stall_write;
        test_reset_mid_write;
        test_wrap;
        test_random;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
